// File: rtl/tensor_stream_sink.sv
// Valid/ready tensor sink: packs each accepted beat into one RAM word, stops after a full frame,
// and serves the stored frame through a 2-cycle addr/ce0/q0 read port.
module tensor_stream_sink #(
  parameter int DATA_IN_TENSOR_SIZE_DIM_0 = 32,
  parameter int DATA_IN_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_PRECISION_0       = 16,
  parameter int DATA_IN_PRECISION_1       = 3,
  parameter int DATA_IN_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_PARALLELISM_DIM_1 = 1,
  parameter int IN_DEPTH   = (DATA_IN_TENSOR_SIZE_DIM_0 * DATA_IN_TENSOR_SIZE_DIM_1) /
                             (DATA_IN_PARALLELISM_DIM_0 * DATA_IN_PARALLELISM_DIM_1),
  parameter int ADDR_WIDTH = $clog2(IN_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_IN_PRECISION_0-1:0] data_in [DATA_IN_PARALLELISM_DIM_0*DATA_IN_PARALLELISM_DIM_1],
  input  logic                           data_in_valid,
  output logic                           data_in_ready,
  input  logic                           clear,
  output logic                           full,
  output logic [7:0]                     frame_count,
  input  logic [ADDR_WIDTH-1:0]          address0,
  input  logic                           ce0,
  output logic [DATA_IN_PRECISION_0*DATA_IN_PARALLELISM_DIM_0*DATA_IN_PARALLELISM_DIM_1-1:0] q0
);

  localparam int PAR    = DATA_IN_PARALLELISM_DIM_0 * DATA_IN_PARALLELISM_DIM_1;
  localparam int WORD_W = DATA_IN_PRECISION_0 * PAR;
  localparam int IDX_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

  // Fixed-point format is bookkeeping only, but a fraction wider than the element is a config error.
  if (DATA_IN_PRECISION_1 >= DATA_IN_PRECISION_0) begin : g_bad_frac
    $error("tensor_stream_sink: fractional bits must be fewer than element width");
  end

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_wr_ptr;
  logic                r_full;
  logic [7:0]          r_frame_count;
  logic [WORD_W-1:0]   r_mem [IN_DEPTH];
  logic [WORD_W-1:0]   r_rd_p0;
  logic [WORD_W-1:0]   r_rd_p1;

  logic                w_accept;
  logic                w_last;
  logic                w_rd_in_range;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [WORD_W-1:0]   w_beat;

  assign data_in_ready = (r_state == S_FILL) && !clear && !rst;
  assign w_accept      = data_in_valid && data_in_ready;
  assign w_last        = (r_wr_ptr == IDX_W'(IN_DEPTH - 1));
  assign w_rd_in_range = (int'(address0) < IN_DEPTH);
  assign w_rd_idx      = address0[IDX_W-1:0];

  always_comb begin
    w_beat = '0;
    for (int j = 0; j < PAR; j++) begin
      w_beat[DATA_IN_PRECISION_0*j +: DATA_IN_PRECISION_0] = data_in[j];
    end
  end

  // Fill/hold control: rst beats clear, clear beats an accept (ready is already low under clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FILL;
      r_wr_ptr      <= '0;
      r_full        <= 1'b0;
      r_frame_count <= 8'd0;
    end else if (clear) begin
      r_state  <= S_FILL;
      r_wr_ptr <= '0;
      r_full   <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_wr_ptr      <= '0;
        r_state       <= S_FULL;
        r_full        <= 1'b1;
        r_frame_count <= r_frame_count + 8'd1;
      end else begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_beat;
    end
  end

  // Read stage p0: RAM fetch (old data on a same-word write); stage p1: output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_p0 <= '0;
      r_rd_p1 <= '0;
    end else if (ce0) begin
      r_rd_p0 <= w_rd_in_range ? r_mem[w_rd_idx] : '0;
      r_rd_p1 <= r_rd_p0;
    end
  end

  assign full        = r_full;
  assign frame_count = r_frame_count;
  assign q0          = r_rd_p1;

endmodule
